// File: rtl/level_transition_ctl.sv
// Level transition sequencer.
// Takes level-up/down requests, freezes the character, fades the picture to
// black on frame boundaries, hands the new level to the background loader over
// a req/ack handshake, then fades back in and releases the freeze. This block
// owns the committed level register.
module level_transition_ctl #(
  parameter int MAX_LEVEL       = 4,
  parameter int LEVEL_W         = 3,
  parameter int FADE_MAX        = 15,
  parameter int FRAMES_PER_STEP = 2,
  parameter int LOAD_TIMEOUT    = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               level_up_req,
  input  logic               level_down_req,
  input  logic               vblnk,
  input  logic               load_ack,
  output logic               load_req,
  output logic [LEVEL_W-1:0] load_level,
  output logic [LEVEL_W-1:0] level,
  output logic               freeze,
  output logic [3:0]         fade,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int FC_W = $clog2(FRAMES_PER_STEP + 1);
  localparam int TO_W = $clog2(LOAD_TIMEOUT + 1);

  localparam logic [3:0]         FADE_FULL  = 4'(FADE_MAX);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(MAX_LEVEL);
  localparam logic [FC_W-1:0]    STEP_LAST  = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(LOAD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    FADE_OUT,
    LOAD,
    FADE_IN
  } state_t;

  state_t             state;
  logic               vblnk_d;
  logic [FC_W-1:0]    frame_cnt;
  logic [TO_W-1:0]    timeout_cnt;
  logic [LEVEL_W-1:0] target;

  logic frame_tick;
  logic step_edge;
  logic up_ok;
  logic down_ok;

  // Rising edge of vblnk marks the start of a frame; a fade step lands on
  // every FRAMES_PER_STEP-th tick.
  assign frame_tick = vblnk & ~vblnk_d;
  assign step_edge  = frame_tick && (frame_cnt == STEP_LAST);

  // Simultaneous up and down requests cancel each other out.
  assign up_ok   = level_up_req && !level_down_req && (level < LEVEL_TOP);
  assign down_ok = level_down_req && !level_up_req && (level != '0);

  // Delayed copy of vblnk for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register in this file uses non-blocking assignment so all
    // state updates see the pre-edge values regardless of statement order.
    if (!rst_n) vblnk_d <= 1'b0;
    else        vblnk_d <= vblnk;
  end

  // Transition sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      level       <= '0;
      load_level  <= '0;
      load_req    <= 1'b0;
      target      <= '0;
      fade        <= FADE_FULL;
      freeze      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      frame_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      // Pulses default low; only a completing transition raises them.
      done <= 1'b0;
      err  <= 1'b0;

      // NOTE: the default arm recovers from unreachable encodings, so the
      // 3-bit state register can never get stuck outside the five states.
      case (state)
        IDLE: begin
          if (up_ok) begin
            target <= level + 1'b1;
            state  <= WAIT_FRAME;
            freeze <= 1'b1;
            busy   <= 1'b1;
          end else if (down_ok) begin
            target <= level - 1'b1;
            state  <= WAIT_FRAME;
            freeze <= 1'b1;
            busy   <= 1'b1;
          end
        end

        WAIT_FRAME: begin
          // Align the first fade step to a frame boundary.
          if (frame_tick) begin
            frame_cnt <= '0;
            state     <= FADE_OUT;
          end
        end

        FADE_OUT: begin
          if (step_edge) begin
            frame_cnt <= '0;
            if (fade <= 4'd1) begin
              fade        <= 4'd0;
              state       <= LOAD;
              load_req    <= 1'b1;
              load_level  <= target;
              timeout_cnt <= '0;
            end else begin
              fade <= fade - 4'd1;
            end
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end

        LOAD: begin
          if (load_ack) begin
            level     <= target;
            load_req  <= 1'b0;
            frame_cnt <= '0;
            state     <= FADE_IN;
          end else if (timeout_cnt == TO_LAST) begin
            // Loader never answered: keep the old level and fade back in.
            load_req  <= 1'b0;
            err       <= 1'b1;
            frame_cnt <= '0;
            state     <= FADE_IN;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        FADE_IN: begin
          if (step_edge) begin
            frame_cnt <= '0;
            if (fade >= FADE_FULL - 4'd1) begin
              fade   <= FADE_FULL;
              state  <= IDLE;
              freeze <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              fade <= fade + 4'd1;
            end
          end else if (frame_tick) begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          freeze <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_transition_ctl.sv
// Self-checking bench for level_transition_ctl: table-driven requests from
// IDLE plus hand-written reset, busy-request, timeout and frame-sync sequences.
// A scoreboard queue holds the expected outcome of every accepted request.
module tb_level_transition_ctl;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       level_up_req;
  logic       level_down_req;
  logic       vblnk;
  logic       load_ack;
  logic       load_req;
  logic [2:0] load_level;
  logic [2:0] level;
  logic       freeze;
  logic [3:0] fade;
  logic       busy;
  logic       done;
  logic       err;

  level_transition_ctl #(
    .MAX_LEVEL      (4),
    .LEVEL_W        (3),
    .FADE_MAX       (15),
    .FRAMES_PER_STEP(2),
    .LOAD_TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .level_up_req  (level_up_req),
    .level_down_req(level_down_req),
    .vblnk         (vblnk),
    .load_ack      (load_ack),
    .load_req      (load_req),
    .load_level    (load_level),
    .level         (level),
    .freeze        (freeze),
    .fade          (fade),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of accepted requests.
  typedef struct {
    int target;
    int final_level;
    int err;
  } exp_t;
  exp_t sb[$];

  // Frame generator: vblnk high for blank_len of every frame_len cycles.
  int frame_len = 8;
  int blank_len = 3;
  int vcnt      = 0;
  initial begin
    vblnk = 1'b0;
    forever begin
      @(negedge clk);
      vcnt  = (vcnt + 1 >= frame_len) ? 0 : vcnt + 1;
      vblnk = (vcnt < blank_len);
    end
  end

  // Independent count of frame ticks as seen at each active edge.
  logic vprev;
  int   tick_total = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vprev <= 1'b0;
    end else begin
      vprev <= vblnk;
      if (vblnk && !vprev) tick_total <= tick_total + 1;
    end
  end

  // Output monitor: scoreboard pops, invariants, fade-on-tick watch.
  logic lr_prev    = 1'b0;
  int   inv_viol   = 0;
  int   err_cnt    = 0;
  int   done_cnt   = 0;
  int   err_in_txn = 0;
  bit   watch_fade = 1'b0;
  int   fade_prev  = 15;
  int   tick_prev  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      lr_prev    = 1'b0;
      err_in_txn = 0;
    end else begin
      if (freeze !== busy) inv_viol++;
      if (done && err) inv_viol++;
      if (load_req && !lr_prev) begin
        check("sb_nonempty_at_load", int'(sb.size() > 0), 1);
        if (sb.size() > 0) check("load_level", load_level, sb[0].target);
      end
      if (err) begin
        err_cnt++;
        err_in_txn = 1;
      end
      if (done) begin
        done_cnt++;
        check("sb_nonempty_at_done", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("final_level", level, e.final_level);
          check("err_in_txn", err_in_txn, e.err);
        end
        err_in_txn = 0;
      end
      if (watch_fade && (int'(fade) != fade_prev))
        check("fade_on_tick", int'(tick_total != tick_prev), 1);
      lr_prev = load_req;
    end
    fade_prev = fade;
    tick_prev = tick_total;
  end

  // Issue one request from IDLE and follow it to completion.
  task automatic request(input bit up, input bit down, input bit exp_busy,
                         input int target, input int exp_level,
                         input bit give_ack, input bit poke_busy);
    int t0, t1, lev0, bad, n, budget;
    lev0   = level;
    budget = 40 * frame_len + 20;
    if (exp_busy) sb.push_back('{target: target, final_level: exp_level,
                                 err: int'(!give_ack)});
    @(negedge clk);
    level_up_req   = up;
    level_down_req = down;
    @(negedge clk);
    level_up_req   = 1'b0;
    level_down_req = 1'b0;
    t0 = tick_total;
    check("busy_next", busy, exp_busy);
    check("freeze_next", freeze, exp_busy);
    if (!exp_busy) begin
      bad = 0;
      repeat (10 * frame_len) begin
        @(negedge clk);
        if (busy || load_req) bad++;
      end
      check("idle_stays", bad, 0);
      check("fade_idle", fade, 15);
      check("level_kept", level, exp_level);
      return;
    end
    if (poke_busy) begin
      for (int i = 0; i < budget && fade != 4'd12; i++) @(negedge clk);
      check("reach_fade12", fade, 12);
      level_up_req = 1'b1;
      @(negedge clk);
      level_up_req = 1'b0;
    end
    for (int i = 0; i < budget && !load_req; i++) @(negedge clk);
    check("load_req_rise", load_req, 1);
    check("ticks_fade_out", tick_total - t0, 31);
    check("fade_black", fade, 0);
    if (give_ack) begin
      bad = 0;
      repeat (5) begin
        @(negedge clk);
        if (!load_req || int'(load_level) != target) bad++;
      end
      check("load_hold", bad, 0);
      load_ack = 1'b1;
      @(negedge clk);
      load_ack = 1'b0;
      check("load_req_drop", load_req, 0);
      check("level_commit", level, exp_level);
    end else begin
      n = 1;
      while (load_req && n < 3 * TO) begin
        @(negedge clk);
        if (load_req) n++;
      end
      check("timeout_cycles", n, TO);
      check("err_pulse", err, 1);
      check("level_no_commit", level, lev0);
    end
    t1 = tick_total;
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check("done_pulse", done, 1);
    check("ticks_fade_in", tick_total - t1, 30);
    check("fade_full", fade, 15);
    check("freeze_released", freeze, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  typedef struct {
    bit up;
    bit down;
    bit exp_busy;
    int exp_level;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int done0;
    vecs[0] = '{up: 1'b0, down: 1'b1, exp_busy: 1'b0, exp_level: 0}; // down at 0
    vecs[1] = '{up: 1'b1, down: 1'b0, exp_busy: 1'b1, exp_level: 1};
    vecs[2] = '{up: 1'b1, down: 1'b0, exp_busy: 1'b1, exp_level: 2};
    vecs[3] = '{up: 1'b1, down: 1'b1, exp_busy: 1'b0, exp_level: 2}; // both
    vecs[4] = '{up: 1'b1, down: 1'b0, exp_busy: 1'b1, exp_level: 3};
    vecs[5] = '{up: 1'b1, down: 1'b0, exp_busy: 1'b1, exp_level: 4};
    vecs[6] = '{up: 1'b1, down: 1'b0, exp_busy: 1'b0, exp_level: 4}; // up at max
    vecs[7] = '{up: 1'b0, down: 1'b1, exp_busy: 1'b1, exp_level: 3};

    rst_n          = 1'b0;
    level_up_req   = 1'b0;
    level_down_req = 1'b0;
    load_ack       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_fade", fade, 15);
    check("rst_busy", busy, 0);
    check("rst_load_req", load_req, 0);
    check("rst_load_level", load_level, 0);
    check("rst_done_err", {done, err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k])
      request(vecs[k].up, vecs[k].down, vecs[k].exp_busy, vecs[k].exp_level,
              vecs[k].exp_level, 1'b1, 1'b0);

    // Reset in the middle of a fade-out (level 3 -> 4 in progress).
    sb.push_back('{target: 4, final_level: 4, err: 0});
    @(negedge clk);
    level_up_req = 1'b1;
    @(negedge clk);
    level_up_req = 1'b0;
    for (int i = 0; i < 400 && fade != 4'd7; i++) @(negedge clk);
    check("reach_fade7", fade, 7);
    rst_n = 1'b0;
    #1;
    check("midrst_fade", fade, 15);
    check("midrst_level", level, 0);
    check("midrst_freeze", freeze, 0);
    check("midrst_load_req", load_req, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_fade", fade, 15);
    check("postrst_level", level, 0);
    check("postrst_busy", busy, 0);

    // Request while busy: second up during 1 -> 2 fade-out is dropped.
    request(1'b1, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0);
    done0 = done_cnt;
    request(1'b1, 1'b0, 1'b1, 2, 2, 1'b1, 1'b1);
    repeat (20 * frame_len) @(negedge clk);
    check("busy_req_one_done", done_cnt - done0, 1);
    check("busy_req_level", level, 2);
    check("busy_req_idle", busy, 0);

    // Load timeout: target 3 never acknowledged, level stays 2.
    request(1'b1, 1'b0, 1'b1, 3, 2, 1'b0, 1'b0);

    // Long vertical blank: only the rising edge may count as a tick.
    frame_len  = 60;
    blank_len  = 50;
    repeat (2 * frame_len) @(negedge clk);
    watch_fade = 1'b1;
    request(1'b0, 1'b1, 1'b1, 1, 1, 1'b1, 1'b0);
    watch_fade = 1'b0;

    check("invariants", inv_viol, 0);
    check("err_total", err_cnt, 1);
    check("done_total", done_cnt, 9);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
